decoder24_seq: RTL and testbench
================================

DECODER24_SEQ -- requirements
Module: decoder24_seq

Interface
REQ-001 Parameter HOLD, default 4, number of clock cycles a decoded one-hot output stays asserted; legal range 1..15.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 i0  input  1  code bit 0 (LSB), driven by the 4-to-2 encoder o0.
REQ-005 i1  input  1  code bit 1 (MSB), driven by the 4-to-2 encoder o1.
REQ-006 in_valid  input  1  code {i1,i0} is valid this cycle.
REQ-007 abort  input  1  synchronous cancel of the current hold.
REQ-008 in_ready  output  1  block accepts a code this cycle.
REQ-009 o0  output  1  one-hot line for code 00.
REQ-010 o1  output  1  one-hot line for code 01.
REQ-011 o2  output  1  one-hot line for code 10.
REQ-012 o3  output  1  one-hot line for code 11.
REQ-013 out_valid  output  1  high whenever any of o0..o3 is high.

Function
REQ-014 A transfer SHALL occur on a rising edge where in_valid=1, in_ready=1 and abort=0.
REQ-015 The FSM SHALL have exactly two states: IDLE and HOLD.
REQ-016 In IDLE: in_ready=1, o0..o3=0, out_valid=0.
REQ-017 In HOLD: in_ready=0, exactly one of o0..o3 high, out_valid=1.
REQ-018 On a transfer in IDLE, the block SHALL latch {i1,i0}, load the hold counter with HOLD-1 and enter HOLD on the next cycle.
REQ-019 Latency: the selected output SHALL rise on the cycle after the transfer edge.
REQ-020 Mapping: code 00->o0, 01->o1, 10->o2, 11->o3.
REQ-021 In HOLD, the counter SHALL decrement once per cycle; the state SHALL return to IDLE on the edge where counter=0.
REQ-022 The selected output SHALL therefore be high for exactly HOLD consecutive cycles.
REQ-023 Back-to-back transfers SHALL be separated by at least one IDLE cycle with all outputs low.
REQ-024 Changes on i0/i1 during HOLD SHALL NOT affect the outputs.
REQ-025 in_valid asserted while in_ready=0 SHALL be ignored, not queued.
REQ-026 abort=1 in HOLD SHALL force IDLE on the next edge, clearing outputs regardless of counter value.
REQ-027 abort=1 in IDLE SHALL block acceptance that cycle; abort takes priority over in_valid.
REQ-028 With HOLD=1, the output SHALL be high for one cycle, then return to IDLE.
REQ-029 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-030 rst=1 on a rising edge SHALL force IDLE, counter=0, latched code=00, o0..o3=0, out_valid=0.
REQ-031 in_ready SHALL be 1 on the first cycle after rst deasserts.
REQ-032 rst SHALL take priority over abort and in_valid, including mid-HOLD.
REQ-033 rst asserted on a transfer edge SHALL discard the transfer.

Structure
REQ-034 Package decoder24_pkg SHALL hold the state enum (IDLE, HOLD), the counter width constant (4) and the HOLD default.
REQ-035 The hold counter SHALL be the sub-module hold_timer (load, decrement, zero flag).
REQ-036 The decode SHALL be implemented in decoder24_seq itself.

Verification
REQ-037 Reset release, HOLD=4, code 10 with in_valid for 1 cycle -> o2 high on cycles 1-4 after the transfer, in_ready low for those 4 cycles.
REQ-038 Codes 00, 01, 10, 11 with in_valid held continuously -> o0, o1, o2, o3 each high for 4 cycles, one all-zero gap cycle between them, no overlap.
REQ-039 Code 11 accepted, abort=1 at hold cycle 2 -> o3 low from cycle 3, in_ready=1 on the same cycle.
REQ-040 Code 01 accepted, i1/i0 toggled and in_valid=1 during HOLD -> o1 stays the only high output for 4 cycles, no extra transfer.
REQ-041 Code 10 accepted, rst=1 at hold cycle 2 -> all outputs 0 on the next cycle, in_ready=1 after rst drops.
REQ-042 HOLD=1, in_valid held with code 00 -> o0 pulses high for 1 cycle, low for 1 cycle, repeating.

Source files
------------

// File: rtl/decoder24_pkg.sv
// Shared types and constants for the sequenced 2-to-4 decoder.
// State encoding, hold counter width and default hold length live here.
package decoder24_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam int CNT_W        = 4;
    localparam int HOLD_DEFAULT = 4;

endpackage

// File: rtl/decoder24_seq_hold_timer.sv
// hold_timer: loadable down-counter with zero flag; 1-cycle load/decrement latency.
// No backpressure; clear overrides load, load overrides decrement, decrement saturates at zero.
module hold_timer
    import decoder24_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             zero
);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/decoder24_seq.sv
// decoder24_seq: accepts a 2-bit code, drives its one-hot line for HOLD cycles; output rises 1 cycle after transfer.
// Backpressure: in_ready drops for the whole hold; codes offered meanwhile are dropped, abort cancels a hold.
module decoder24_seq
    import decoder24_pkg::*;
#(
    parameter int HOLD = HOLD_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic i0,
    input  logic i1,
    input  logic in_valid,
    input  logic abort,
    output logic in_ready,
    output logic o0,
    output logic o1,
    output logic o2,
    output logic o3,
    output logic out_valid
);

    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(HOLD - 1);

    state_t           state;
    logic [1:0]       code;
    logic [3:0]       onehot_q;
    logic [3:0]       onehot_d;
    logic             transfer;
    logic             in_hold;
    logic [CNT_W-1:0] count;
    logic             cnt_zero;

    // in_ready is a register that mirrors IDLE, so gating on it keeps abort/valid off the output path.
    assign transfer = in_ready && in_valid && !abort;
    assign in_hold  = (state == decoder24_pkg::HOLD);

    always_comb begin
        onehot_d = 4'b0000;
        unique case ({i1, i0})
            2'b00:   onehot_d = 4'b0001;
            2'b01:   onehot_d = 4'b0010;
            2'b10:   onehot_d = 4'b0100;
            default: onehot_d = 4'b1000;
        endcase
    end

    hold_timer u_hold_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (abort),
        .load     (transfer),
        .load_val (LOAD_VAL),
        .dec      (in_hold),
        .count    (count),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= decoder24_pkg::IDLE;
            code      <= 2'b00;
            onehot_q  <= 4'b0000;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            unique case (state)
                decoder24_pkg::IDLE: begin
                    if (transfer) begin
                        state     <= decoder24_pkg::HOLD;
                        code      <= {i1, i0};
                        onehot_q  <= onehot_d;
                        out_valid <= 1'b1;
                        in_ready  <= 1'b0;
                    end
                end
                decoder24_pkg::HOLD: begin
                    if (abort || cnt_zero) begin
                        state     <= decoder24_pkg::IDLE;
                        onehot_q  <= 4'b0000;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= decoder24_pkg::IDLE;
                    onehot_q  <= 4'b0000;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign o0 = onehot_q[0];
    assign o1 = onehot_q[1];
    assign o2 = onehot_q[2];
    assign o3 = onehot_q[3];

    // The latched code is kept for debug visibility; the outputs come from onehot_q.
    logic unused_ok;
    assign unused_ok = ^{code, count};

endmodule

// File: tb/tb_decoder24_seq.sv
// Randomized and directed bench for decoder24_seq, HOLD=4 and HOLD=1 instances on shared stimulus.
// A remaining-cycles reference model predicts {in_ready,out_valid,o3,o2,o1,o0} every cycle.
module tb_decoder24_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic i0 = 1'b0;
    logic i1 = 1'b0;
    logic in_valid = 1'b0;
    logic abort = 1'b0;

    logic rdy_a, o0_a, o1_a, o2_a, o3_a, ov_a;
    logic rdy_b, o0_b, o1_b, o2_b, o3_b, ov_b;

    int checks = 0;
    int errors = 0;

    // Reference model: cycles of output still to show and the code being shown.
    int         rem_a = 0, rem_b = 0;
    logic [1:0] mcode_a = 2'b00, mcode_b = 2'b00;
    int         acc_a = 0;

    always #5 clk = ~clk;

    decoder24_seq #(.HOLD(4)) dut_a (
        .clk(clk), .rst(rst), .i0(i0), .i1(i1), .in_valid(in_valid), .abort(abort),
        .in_ready(rdy_a), .o0(o0_a), .o1(o1_a), .o2(o2_a), .o3(o3_a), .out_valid(ov_a)
    );

    decoder24_seq #(.HOLD(1)) dut_b (
        .clk(clk), .rst(rst), .i0(i0), .i1(i1), .in_valid(in_valid), .abort(abort),
        .in_ready(rdy_b), .o0(o0_b), .o1(o1_b), .o2(o2_b), .o3(o3_b), .out_valid(ov_b)
    );

    task automatic chk(input string tag, input logic [5:0] got, input logic [5:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", tag, $time, got, exp);
        end
    endtask

    function automatic logic [5:0] expect_vec(input int rem, input logic [1:0] c);
        logic [5:0] v;
        v = 6'b100000;
        if (rem > 0) begin
            v = 6'b010000;
            v[c] = 1'b1;
        end
        return v;
    endfunction

    function automatic logic [5:0] obs_a();
        return {rdy_a, ov_a, o3_a, o2_a, o1_a, o0_a};
    endfunction

    function automatic logic [5:0] obs_b();
        return {rdy_b, ov_b, o3_b, o2_b, o1_b, o0_b};
    endfunction

    // Advance one clock: drive inputs, let both model and DUT take the edge, then compare.
    task automatic step(input logic r, input logic v, input logic [1:0] c, input logic ab);
        rst = r; in_valid = v; {i1, i0} = c; abort = ab;
        @(posedge clk);
        if (r) begin
            rem_a = 0; mcode_a = 2'b00;
            rem_b = 0; mcode_b = 2'b00;
        end else begin
            if (rem_a == 0) begin
                if (v && !ab) begin rem_a = 4; mcode_a = c; acc_a++; end
            end else begin
                rem_a = ab ? 0 : rem_a - 1;
            end
            if (rem_b == 0) begin
                if (v && !ab) begin rem_b = 1; mcode_b = c; end
            end else begin
                rem_b = ab ? 0 : rem_b - 1;
            end
        end
        @(negedge clk);
        chk("cycle_hold4", obs_a(), expect_vec(rem_a, mcode_a));
        chk("cycle_hold1", obs_b(), expect_vec(rem_b, mcode_b));
    endtask

    initial begin
        logic [1:0] seq [4];
        seq = '{2'b00, 2'b01, 2'b10, 2'b11};

        step(1, 0, 2'b00, 0);
        step(1, 1, 2'b11, 1);
        chk("reset_state_a", obs_a(), 6'b100000);
        chk("reset_state_b", obs_b(), 6'b100000);

        // Single code 10 for one cycle: o2 for exactly four cycles, then idle.
        step(0, 1, 2'b10, 0);
        chk("first_xfer_o2", obs_a(), 6'b010100);
        for (int k = 0; k < 3; k++) step(0, 0, 2'b00, 0);
        chk("o2_last_cycle", obs_a(), 6'b010100);
        step(0, 0, 2'b00, 0);
        chk("after_hold_idle", obs_a(), 6'b100000);
        for (int k = 0; k < 2; k++) step(0, 0, 2'b00, 0);

        // in_valid held, code advances after each acceptance by the HOLD=4 instance.
        acc_a = 0;
        for (int k = 0; k < 22; k++) step(0, 1, seq[acc_a % 4], 0);
        step(0, 0, 2'b00, 0);
        for (int k = 0; k < 4; k++) step(0, 0, 2'b00, 0);

        // Code 11 then abort on the second hold cycle.
        step(0, 1, 2'b11, 0);
        step(0, 0, 2'b00, 0);
        step(0, 0, 2'b00, 1);
        chk("abort_clears", obs_a(), 6'b100000);
        for (int k = 0; k < 3; k++) step(0, 0, 2'b00, 0);

        // Code 01 then noisy inputs during the hold: no effect, no extra transfer.
        step(0, 1, 2'b01, 0);
        for (int k = 0; k < 3; k++) step(0, 1, 2'(k + 2), 0);
        chk("noise_ignored", obs_a(), 6'b010010);
        step(0, 0, 2'b00, 0);
        chk("noise_no_requeue", obs_a(), 6'b100000);

        // Code 10 then reset on the second hold cycle.
        step(0, 1, 2'b10, 0);
        step(0, 0, 2'b00, 0);
        step(1, 1, 2'b11, 0);
        chk("rst_mid_hold", obs_a(), 6'b100000);
        step(0, 0, 2'b00, 0);
        chk("ready_after_rst", obs_a(), 6'b100000);

        // HOLD=1 instance with code 00 held: one-cycle pulse, one-cycle gap.
        for (int k = 0; k < 8; k++) step(0, 1, 2'b00, 0);

        for (int k = 0; k < 2000; k++) begin
            step(($urandom_range(99) < 2), ($urandom_range(99) < 55),
                 2'($urandom_range(3)), ($urandom_range(99) < 10));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
